// File: rtl/ld_cell_pkg.sv
// Shared constants, watchdog state and flag payload for the load-cell conditioning stage.
// Default thresholds are also consumed by the steering state machine bench.
package ld_cell_pkg;

    localparam int unsigned LD_W   = 12;
    localparam int unsigned SUM_W  = 13;
    localparam int unsigned IDLE_W = 20;

    localparam int unsigned        TMR_BITS_DFLT         = 26;
    localparam logic [SUM_W-1:0]   MIN_RIDER_WEIGHT_DFLT = 13'h0200;
    localparam logic [SUM_W-1:0]   HYSTERESIS_DFLT       = 13'h0040;
    localparam logic [IDLE_W-1:0]  STALE_CYCLES_DFLT     = 20'hF_FFFF;

    typedef enum logic [1:0] {
        NO_DATA = 2'd0,
        LIVE    = 2'd1,
        STALE   = 2'd2
    } wd_state_t;

    typedef struct packed {
        logic sum_gt_min;
        logic sum_lt_min;
        logic diff_gt_1_4;
        logic diff_gt_15_16;
    } ld_flags_t;

    // Values presented to the steering machine whenever the load data cannot be trusted.
    localparam ld_flags_t FLAGS_SAFE = '{
        sum_gt_min:    1'b0,
        sum_lt_min:    1'b1,
        diff_gt_1_4:   1'b0,
        diff_gt_15_16: 1'b0
    };

    function automatic logic [SUM_W-1:0] abs_diff(input logic [LD_W-1:0] a,
                                                  input logic [LD_W-1:0] b);
        return (a >= b) ? SUM_W'(a - b) : SUM_W'(b - a);
    endfunction

    function automatic ld_flags_t eval_flags(input logic [SUM_W-1:0] sum,
                                             input logic [SUM_W-1:0] diff,
                                             input logic [SUM_W-1:0] hi_thr,
                                             input logic [SUM_W-1:0] lo_thr);
        ld_flags_t f;
        f.sum_gt_min    = (sum > hi_thr);
        f.sum_lt_min    = (sum < lo_thr);
        f.diff_gt_1_4   = (diff > (sum >> 2));
        f.diff_gt_15_16 = (diff > (sum - (sum >> 4)));
        return f;
    endfunction

endpackage

// File: rtl/ld_cell_cond_if.sv
// Sample/flag bundle between the load-cell front end, this stage and the steering machine.
interface ld_cell_cond_if;
    import ld_cell_pkg::*;

    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            ld_vld;
    logic            clr_tmr;
    logic            sum_gt_min;
    logic            sum_lt_min;
    logic            diff_gt_1_4;
    logic            diff_gt_15_16;
    logic            tmr_full;
    logic            ld_stale;

    modport master (
        output lft_ld, rght_ld, ld_vld, clr_tmr,
        input  sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, ld_stale
    );

    modport slave (
        input  lft_ld, rght_ld, ld_vld, clr_tmr,
        output sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, ld_stale
    );

endinterface

// File: rtl/ld_cell_cond_settle_tmr.sv
// Rider-settle timer: free-running saturating counter, cleared by the steering machine.
module settle_tmr #(
    parameter int unsigned TMR_BITS = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic full
);

    logic [TMR_BITS-1:0] cnt;

    // Clear has priority so a clear on the saturation cycle drops full on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + TMR_BITS'(1);
        end
    end

    assign full = &cnt;

endmodule

// File: rtl/ld_cell_cond.sv
// Load-cell conditioning: captures left/right samples, derives rider-present and imbalance
// flags, and forces safe flags when the sample stream goes silent.
module ld_cell_cond
    import ld_cell_pkg::*;
#(
    parameter logic [SUM_W-1:0]  MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DFLT,
    parameter logic [SUM_W-1:0]  HYSTERESIS       = HYSTERESIS_DFLT,
    parameter int unsigned       TMR_BITS         = TMR_BITS_DFLT,
    parameter logic [IDLE_W-1:0] STALE_CYCLES     = STALE_CYCLES_DFLT
) (
    input logic           clk,
    input logic           rst,
    ld_cell_cond_if.slave bus
);

    localparam logic [SUM_W-1:0] HI_THR = MIN_RIDER_WEIGHT + HYSTERESIS;
    localparam logic [SUM_W-1:0] LO_THR = MIN_RIDER_WEIGHT - HYSTERESIS;

    logic [LD_W-1:0]   lft_q;
    logic [LD_W-1:0]   rght_q;
    logic              v1;
    logic [SUM_W-1:0]  sum_c;
    logic [SUM_W-1:0]  diff_c;
    ld_flags_t         calc_c;

    wd_state_t         state_q;
    wd_state_t         state_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    ld_flags_t         flags_q;
    ld_flags_t         flags_d;
    logic              stale_q;
    logic              stale_d;
    logic              tmr_full;

    // Stage 1: sample capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= bus.ld_vld;
            if (bus.ld_vld) begin
                lft_q  <= bus.lft_ld;
                rght_q <= bus.rght_ld;
            end
        end
    end

    // Stage 2 datapath: 13-bit sum cannot overflow two 12-bit operands.
    assign sum_c  = SUM_W'(lft_q) + SUM_W'(rght_q);
    assign diff_c = abs_diff(lft_q, rght_q);
    assign calc_c = eval_flags(sum_c, diff_c, HI_THR, LO_THR);

    // Watchdog next-state and flag update.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        flags_d = flags_q;
        stale_d = stale_q;

        if (bus.ld_vld) begin
            idle_d = '0;
        end else if (idle_q != STALE_CYCLES) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        case (state_q)
            NO_DATA: if (bus.ld_vld) state_d = LIVE;
            LIVE:    if (!bus.ld_vld && (idle_q == STALE_CYCLES)) state_d = STALE;
            STALE:   if (bus.ld_vld) state_d = LIVE;
            default: state_d = NO_DATA;
        endcase

        if (v1) begin
            flags_d = calc_c;
            stale_d = 1'b0;
        end

        // Forced values stay until a fresh sample reaches stage 2.
        if ((state_q == LIVE) && (state_d == STALE)) begin
            flags_d = FLAGS_SAFE;
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NO_DATA;
            idle_q  <= '0;
            flags_q <= FLAGS_SAFE;
            stale_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            flags_q <= flags_d;
            stale_q <= stale_d;
        end
    end

    settle_tmr #(
        .TMR_BITS (TMR_BITS)
    ) u_settle_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.clr_tmr),
        .full (tmr_full)
    );

    assign bus.sum_gt_min    = flags_q.sum_gt_min;
    assign bus.sum_lt_min    = flags_q.sum_lt_min;
    assign bus.diff_gt_1_4   = flags_q.diff_gt_1_4;
    assign bus.diff_gt_15_16 = flags_q.diff_gt_15_16;
    assign bus.tmr_full      = tmr_full;
    assign bus.ld_stale      = stale_q;

endmodule

// File: tb/tb_ld_cell_cond.sv
// Scoreboard bench for ld_cell_cond: a spec-level model queues the expected outputs for
// every cycle and an independent monitor compares them against the DUT.
module tb_ld_cell_cond;

    localparam int unsigned TB    = 8;
    localparam int unsigned STALE = 40;
    localparam int          TMAX  = (1 << TB) - 1;
    localparam int          HI    = 'h200 + 'h40;
    localparam int          LO    = 'h200 - 'h40;

    typedef struct {
        int tag;
        bit gt;
        bit lt;
        bit d14;
        bit d1516;
        bit full;
        bit stale;
    } exp_t;

    typedef struct {
        int due;
        int l;
        int r;
    } smp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    exp_t exp_q[$];

    ld_cell_cond_if bus ();

    ld_cell_cond #(
        .TMR_BITS     (TB),
        .STALE_CYCLES (20'(STALE))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic got, input bit want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, want);
        end
    endtask

    // ---------------- reference model (spec rules, plain arithmetic) ----------------
    smp_t pend[$];
    int   m_silence;
    int   m_wd;          // 0 no data yet, 1 live, 2 stale
    int   m_tmr;
    bit   m_gt, m_lt, m_d14, m_d1516, m_stale;

    task automatic apply_safe();
        m_gt = 0; m_lt = 1; m_d14 = 0; m_d1516 = 0; m_stale = 1;
    endtask

    always @(posedge clk) begin
        smp_t s;
        exp_t e;
        int   sum, dif;
        cyc++;
        if (rst) begin
            pend.delete();
            m_silence = 0;
            m_wd      = 0;
            m_tmr     = 0;
            apply_safe();
        end else begin
            if (pend.size() != 0 && pend[0].due == cyc) begin
                s   = pend.pop_front();
                sum = s.l + s.r;
                dif = (s.l > s.r) ? s.l - s.r : s.r - s.l;
                m_gt    = sum > HI;
                m_lt    = sum < LO;
                m_d14   = dif > sum / 4;
                m_d1516 = dif > sum - sum / 16;
                m_stale = 0;
            end
            if (bus.ld_vld) begin
                s.due = cyc + 1;
                s.l   = int'(bus.lft_ld);
                s.r   = int'(bus.rght_ld);
                pend.push_back(s);
                m_silence = 0;
                m_wd      = 1;
            end else begin
                m_silence++;
                if (m_wd == 1 && m_silence > int'(STALE)) begin
                    m_wd = 2;
                    apply_safe();
                end
            end
            if (bus.clr_tmr) m_tmr = 0;
            else if (m_tmr < TMAX) m_tmr++;
        end
        e.tag = cyc; e.gt = m_gt; e.lt = m_lt; e.d14 = m_d14; e.d1516 = m_d1516;
        e.full = (m_tmr == TMAX); e.stale = m_stale;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum_gt_min",    bus.sum_gt_min,    e.gt);
            chk("sum_lt_min",    bus.sum_lt_min,    e.lt);
            chk("diff_gt_1_4",   bus.diff_gt_1_4,   e.d14);
            chk("diff_gt_15_16", bus.diff_gt_15_16, e.d1516);
            chk("tmr_full",      bus.tmr_full,      e.full);
            chk("ld_stale",      bus.ld_stale,      e.stale);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input int l, input int r);
        bus.lft_ld  = 12'(l);
        bus.rght_ld = 12'(r);
        bus.ld_vld  = 1'b1;
        tick();
        bus.ld_vld  = 1'b0;
    endtask

    initial begin
        int n;
        int h;
        cyc = 0; errors = 0; checks = 0;
        rst = 1'b1;
        bus.lft_ld = '0; bus.rght_ld = '0; bus.ld_vld = 1'b0; bus.clr_tmr = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(100);

        // rider present, then hysteresis sweep and imbalance cases
        sample('h150, 'h150); idle(3);
        sample('h0DF, 'h0E0); idle(2);
        sample('h0E0, 'h0E0); idle(2);
        sample('h120, 'h120); idle(2);
        sample('h120, 'h121); idle(2);
        sample('h200, 'h080); idle(2);
        sample('h290, 'h000); idle(2);
        sample('hFFF, 'hFFF); idle(2);
        sample('h000, 'h000); idle(2);
        sample('h001, 'h000);
        sample('h100, 'h300);
        sample('h2A0, 'h010);

        // settle timer: rise distance after a clear, then clear while saturated
        bus.clr_tmr = 1'b1; tick(); bus.clr_tmr = 1'b0;
        n = 0;
        while (bus.tmr_full !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != TMAX) begin
            errors++;
            $display("FAIL tmr_rise_dist got=%0d exp=%0d", n, TMAX);
        end
        idle(5);
        chk("tmr_full_held", bus.tmr_full, 1'b1);
        bus.clr_tmr = 1'b1; tick(); bus.clr_tmr = 1'b0;
        chk("tmr_clr_full", bus.tmr_full, 1'b0);

        // watchdog: trip, recover, and a sample on the trip cycle
        sample('h180, 'h100); idle(int'(STALE) + 10);
        chk("wd_tripped", bus.ld_stale, 1'b1);
        sample('h180, 'h100); idle(1);
        chk("wd_recovered", bus.ld_stale, 1'b0);
        sample('h150, 'h100); idle(int'(STALE));
        sample('h150, 'h100); idle(2);
        chk("wd_trip_cycle_vld", bus.ld_stale, 1'b0);
        idle(int'(STALE) + 3);

        // reset with a sample in flight
        sample('h300, 'h300);
        rst = 1'b1; tick(); rst = 1'b0;
        idle(3);

        // randomized traffic with clears and occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.clr_tmr = ($urandom_range(0, 40) == 0);
            rst         = ($urandom_range(0, 200) == 0);
            bus.ld_vld  = ($urandom_range(0, 2) != 0) && (i % 150 < 100);
            case ($urandom_range(0, 2))
                0: begin
                    bus.lft_ld  = 12'($urandom_range(0, 4095));
                    bus.rght_ld = 12'($urandom_range(0, 4095));
                end
                1: begin
                    h = int'($urandom_range('hD8, 'h128));
                    bus.lft_ld  = 12'(h);
                    bus.rght_ld = 12'(h + int'($urandom_range(0, 1)));
                end
                default: begin
                    bus.lft_ld  = 12'($urandom_range(0, 'h400));
                    bus.rght_ld = 12'($urandom_range(0, 'h20));
                end
            endcase
            tick();
        end
        rst = 1'b0; bus.ld_vld = 1'b0; bus.clr_tmr = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ld_cell_cond.md
# ld_cell_cond

Load-cell conditioning stage that sits directly upstream of the steering-enable state machine. It captures left/right rider-platform load samples and computes the sum and absolute difference. It produces the registered threshold flags that machine consumes: sum_gt_min and sum_lt_min (with hysteresis), diff_gt_1_4 and diff_gt_15_16. It also owns the ~1.3 s rider-settle timer (clr_tmr in, tmr_full out) and a stale-sample watchdog that forces a safe "rider off" indication when samples stop arriving.

## Interface
- MIN_RIDER_WEIGHT, 13'h0200, nominal rider-present threshold on the sum
- HYSTERESIS, 13'h0040, band half-width around MIN_RIDER_WEIGHT
- TMR_BITS, 26, settle-timer width; full at all-ones (2^26-1 cycles ≈ 1.34 s at 50 MHz)
- STALE_CYCLES, 20'hF_FFFF, cycles without ld_vld before watchdog trips
- clk  input  1  50 MHz system clock
- rst  input  1  synchronous, active-high reset
- lft_ld  input  12  left load-cell sample, unsigned
- rght_ld  input  12  right load-cell sample, unsigned
- ld_vld  input  1  single-cycle strobe, samples valid this cycle
- clr_tmr  input  1  synchronous clear of settle timer (from steering SM)
- sum_gt_min  output  1  sum > MIN_RIDER_WEIGHT + HYSTERESIS
- sum_lt_min  output  1  sum < MIN_RIDER_WEIGHT - HYSTERESIS
- diff_gt_1_4  output  1  |lft-rght| > sum/4
- diff_gt_15_16  output  1  |lft-rght| > 15/16 sum
- tmr_full  output  1  settle timer saturated
- ld_stale  output  1  no valid sample yet / watchdog tripped

## Operation
- Stage 1 (capture): on ld_vld, lft_ld/rght_ld registered into lft_q/rght_q; capture-valid flag v1 set for one cycle.
- Stage 2 (compute/compare, when v1): sum = lft_q + rght_q (13 bit, no overflow); diff = |lft_q - rght_q| (12 bit, zero-extended to 13); all flags registered:
  - sum_gt_min = sum > (MIN_RIDER_WEIGHT + HYSTERESIS); sum_lt_min = sum < (MIN_RIDER_WEIGHT - HYSTERESIS); both 0 inside the band.
  - diff_gt_1_4 = diff > (sum >> 2); diff_gt_15_16 = diff > (sum - (sum >> 4)); truncating shifts, unsigned compares.
- Flags hold between samples.
- Watchdog states: NO_DATA, LIVE, STALE.
  - NO_DATA (reset state) -> LIVE on the first ld_vld.
  - LIVE -> STALE when the idle counter reaches STALE_CYCLES.
  - STALE -> LIVE on ld_vld.
  - Idle counter clears on every ld_vld and saturates at STALE_CYCLES.
  - In NO_DATA/STALE: ld_stale=1; safe values forced: sum_gt_min=0, sum_lt_min=1, diff_gt_1_4=0, diff_gt_15_16=0.
  - ld_stale clears when stage 2 writes flags from the new sample, so forced values persist until real data replaces them.
- Settle timer: TMR_BITS counter, increments each cycle, saturates at all-ones. clr_tmr zeroes it (priority over increment). tmr_full = counter is all-ones, decoded from the register.

## Timing
- Reset values: sum_gt_min=0, sum_lt_min=1, diff_gt_1_4=0, diff_gt_15_16=0, tmr_full=0, ld_stale=1; timer=0, idle counter=0, state NO_DATA.
- Flag latency: ld_vld in cycle N -> flags valid from edge ending cycle N+1 (visible cycle N+2).
- Back-to-back ld_vld every cycle supported; each sample produces its own flag update.
- ld_vld in the same cycle the idle counter reaches STALE_CYCLES: ld_vld wins; no STALE entry.
- clr_tmr in the same cycle as saturation: the counter reads 0 next cycle and tmr_full deasserts next cycle.
- After clr_tmr at cycle N, tmr_full rises exactly 2^TMR_BITS-1 cycles later.
- rst mid-operation (any state, pipeline in flight): in-flight sample discarded; all registers return to reset values on that edge.

## Structure
- Package ld_cell_pkg: watchdog state typedef (NO_DATA, LIVE, STALE); default MIN_RIDER_WEIGHT, HYSTERESIS, STALE_CYCLES constants shared with the steering SM testbench.
- Sub-module settle_tmr (parameter TMR_BITS; ports clk, rst, clr, full) holds the timer. Everything else is inline.

## Test plan
- Reset, no ld_vld for 100 cycles -> ld_stale=1, sum_lt_min=1, sum_gt_min=0, both diff flags 0.
- ld_vld with lft=0x150, rght=0x150 (sum 0x2A0) -> two cycles later: sum_gt_min=1, sum_lt_min=0, diff_gt_1_4=0, ld_stale=0.
- Hysteresis sweep, equal halves, sums 0x1BF / 0x1C0 / 0x240 / 0x241:
  - 0x1BF -> sum_lt_min=1.
  - 0x1C0 and 0x240 -> both sum flags 0.
  - 0x241 -> sum_gt_min=1.
- lft=0x200, rght=0x080 (sum 0x280, diff 0x180) -> diff_gt_1_4=1, diff_gt_15_16=0. Then lft=0x290, rght=0x000 -> diff_gt_15_16=1.
- Timer with TMR_BITS=8: clr_tmr pulse -> tmr_full high at cycle 255 after the clear. clr_tmr while full -> tmr_full low the next cycle.
- Watchdog: sample, then silence of STALE_CYCLES cycles -> ld_stale=1 and safe flags forced. A new sample restores computed flags in 2 cycles. ld_vld on the trip cycle -> no stale entry.
